// File: rtl/alu_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | alu_pkg : shared ALU width, opcode encoding and arbiter FSM states     |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
package alu_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_NOR = 3'd3,
        OP_XOR = 3'd4,
        OP_SHL = 3'd5,
        OP_SHR = 3'd6,
        OP_SRA = 3'd7
    } alu_op_e;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_EXEC = 2'd1;
    localparam state_t ST_RESP = 2'd2;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_arbiter_alu.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | alu_arbiter_alu : 8-bit combinational ALU, no carry out                |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
module alu_arbiter_alu
    import alu_pkg::*;
(
    input  logic [2:0]        i_op,
    input  logic [DATA_W-1:0] i_x,
    input  logic [DATA_W-1:0] i_y,
    output logic [DATA_W-1:0] o_result
);

    always_comb begin
        o_result = '0;
        case (i_op)
            OP_ADD:  o_result = i_x + i_y;
            OP_SUB:  o_result = i_x - i_y;
            OP_AND:  o_result = i_x & i_y;
            OP_NOR:  o_result = ~(i_x | i_y);
            OP_XOR:  o_result = i_x ^ i_y;
            OP_SHL:  o_result = i_x << i_y;
            OP_SHR:  o_result = i_x >> i_y;
            // Operands are unsigned, so the arithmetic shift fills with zero.
            OP_SRA:  o_result = i_x >> i_y;
            default: o_result = '0;
        endcase
    end

endmodule : alu_arbiter_alu
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | alu_arbiter : round-robin sharing of one ALU among NREQ requesters     |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
module alu_arbiter #(
    parameter int NREQ   = 2,
    parameter int DATA_W = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [NREQ-1:0]          i_req_valid,
    output logic [NREQ-1:0]          o_req_ready,
    input  logic [3*NREQ-1:0]        i_req_op,
    input  logic [DATA_W*NREQ-1:0]   i_req_x,
    input  logic [DATA_W*NREQ-1:0]   i_req_y,
    output logic                     o_rsp_valid,
    input  logic                     i_rsp_ready,
    output logic [$clog2(NREQ)-1:0]  o_rsp_id,
    output logic [DATA_W-1:0]        o_rsp_result,
    output logic                     o_busy
);

    import alu_pkg::*;

    localparam int IDW = $clog2(NREQ);

    state_t            state_q, state_d;
    logic [IDW-1:0]    last_q, last_d;
    logic [IDW-1:0]    id_q, id_d;
    logic [2:0]        op_q, op_d;
    logic [DATA_W-1:0] x_q, x_d;
    logic [DATA_W-1:0] y_q, y_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic [IDW-1:0]    rsp_id_q, rsp_id_d;

    logic [IDW-1:0]    w_win;
    logic              w_any;
    logic              w_accept;
    logic [DATA_W-1:0] w_alu;

    // First valid index strictly after the last grant, wrapping around.
    function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] valid,
                                               input logic [IDW-1:0]  last);
        logic [IDW-1:0] win;
        logic           found;
        int             idx;
        win   = last;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last) + k) % NREQ;
            if (!found && valid[idx]) begin
                win   = idx[IDW-1:0];
                found = 1'b1;
            end
        end
        return win;
    endfunction

    assign w_win    = rr_pick(i_req_valid, last_q);
    assign w_any    = |i_req_valid;
    assign w_accept = |(i_req_valid & o_req_ready);

    always_comb begin
        o_req_ready = '0;
        if (i_rst_n && (state_q == ST_IDLE) && w_any) begin
            o_req_ready[w_win] = 1'b1;
        end
    end

    alu_arbiter_alu u_alu (
        .i_op     (op_q),
        .i_x      (x_q),
        .i_y      (y_q),
        .o_result (w_alu)
    );

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        id_d     = id_q;
        op_d     = op_q;
        x_d      = x_q;
        y_d      = y_q;
        res_d    = res_q;
        rsp_id_d = rsp_id_q;
        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    last_d  = w_win;
                    id_d    = w_win;
                    op_d    = i_req_op[int'(w_win)*3 +: 3];
                    x_d     = i_req_x[int'(w_win)*DATA_W +: DATA_W];
                    y_d     = i_req_y[int'(w_win)*DATA_W +: DATA_W];
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                res_d    = w_alu;
                rsp_id_d = id_q;
                state_d  = ST_RESP;
            end
            ST_RESP: begin
                if (i_rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            last_q   <= IDW'(NREQ - 1);
            id_q     <= '0;
            op_q     <= '0;
            x_q      <= '0;
            y_q      <= '0;
            res_q    <= '0;
            rsp_id_q <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            id_q     <= id_d;
            op_q     <= op_d;
            x_q      <= x_d;
            y_q      <= y_d;
            res_q    <= res_d;
            rsp_id_q <= rsp_id_d;
        end
    end

    assign o_rsp_valid  = (state_q == ST_RESP);
    assign o_rsp_id     = rsp_id_q;
    assign o_rsp_result = res_q;
    assign o_busy       = (state_q != ST_IDLE);

endmodule : alu_arbiter
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_alu_arbiter : directed self-checking bench for alu_arbiter, NREQ=2  |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
module tb_alu_arbiter;

    logic        i_clk;
    logic        i_rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [5:0]  req_op;
    logic [15:0] req_x;
    logic [15:0] req_y;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [7:0]  rsp_result;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [2:0] op;
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] r;
    } vec_t;

    alu_arbiter #(.NREQ(2), .DATA_W(8)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_op     (req_op),
        .i_req_x      (req_x),
        .i_req_y      (req_y),
        .o_rsp_valid  (rsp_valid),
        .i_rsp_ready  (rsp_ready),
        .o_rsp_id     (rsp_id),
        .o_rsp_result (rsp_result),
        .o_busy       (busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic step();
        @(posedge i_clk);
        #2;
    endtask

    task automatic set_req(input int k, input logic [2:0] op,
                           input logic [7:0] x, input logic [7:0] y);
        req_op[k*3 +: 3] = op;
        req_x[k*8 +: 8]  = x;
        req_y[k*8 +: 8]  = y;
    endtask

    task automatic test_reset();
        i_rst_n   = 1'b0;
        req_valid = 2'b11;
        step();
        step();
        #1;
        n_chk++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b want 00", req_ready); end
        n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_chk++; if (rsp_id !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_id: got %b want 0", rsp_id); end
        n_chk++; if (rsp_result !== 8'h00) begin n_fail++; $display("FAIL reset_result: got %h want 00", rsp_result); end
        i_rst_n = 1'b1;
        #1;
        n_chk++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL reset_first_winner: got %b want 01", req_ready); end
        req_valid = 2'b00;
        #1;
        n_chk++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL idle_no_req_ready: got %b want 00", req_ready); end
        step();
        #1;
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_hold_busy: got %b want 0", busy); end
    endtask

    task automatic test_contention();
        logic       g;
        logic [1:0] er;
        logic [7:0] eres;
        int         ph;
        set_req(0, 3'd0, 8'h01, 8'h02);
        set_req(1, 3'd4, 8'hAA, 8'hFF);
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        g = 1'b0;
        for (int c = 0; c < 12; c++) begin
            #1;
            ph = c % 3;
            er = (ph == 0) ? (2'b01 << g) : 2'b00;
            n_chk++; if (req_ready !== er) begin n_fail++; $display("FAIL cont_ready c%0d: got %b want %b", c, req_ready, er); end
            if (ph == 2) begin
                eres = g ? 8'h55 : 8'h03;
                n_chk++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL cont_rsp_valid c%0d: got %b want 1", c, rsp_valid); end
                n_chk++; if (rsp_id !== g) begin n_fail++; $display("FAIL cont_rsp_id c%0d: got %b want %b", c, rsp_id, g); end
                n_chk++; if (rsp_result !== eres) begin n_fail++; $display("FAIL cont_result c%0d: got %h want %h", c, rsp_result, eres); end
                g = ~g;
            end else begin
                n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL cont_rsp_idle c%0d: got %b want 0", c, rsp_valid); end
            end
            step();
        end
        req_valid = 2'b00;
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        set_req(0, 3'd1, 8'h80, 8'h01);
        set_req(1, 3'd2, 8'h3C, 8'h0F);
        req_valid = 2'b11;
        #1;
        n_chk++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL bp_grant0: got %b want 01", req_ready); end
        step();
        req_valid = 2'b10;
        #1;
        n_chk++; if (req_ready !== 2'b00 || busy !== 1'b1) begin n_fail++; $display("FAIL bp_exec: got ready=%b busy=%b want 00/1", req_ready, busy); end
        step();
        for (int i = 0; i < 5; i++) begin
            #1;
            n_chk++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid %0d: got %b want 1", i, rsp_valid); end
            n_chk++; if (rsp_result !== 8'h7F || rsp_id !== 1'b0) begin n_fail++; $display("FAIL bp_hold_data %0d: got %h/%b want 7f/0", i, rsp_result, rsp_id); end
            n_chk++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL bp_hold_ready %0d: got %b want 00", i, req_ready); end
            step();
        end
        rsp_ready = 1'b1;
        #1;
        n_chk++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_release_valid: got %b want 1", rsp_valid); end
        step();
        #1;
        n_chk++; if (rsp_valid !== 1'b0 || req_ready !== 2'b10) begin n_fail++; $display("FAIL bp_after: got valid=%b ready=%b want 0/10", rsp_valid, req_ready); end
        step();
        req_valid = 2'b00;
        step();
        #1;
        n_chk++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_result !== 8'h0C) begin n_fail++; $display("FAIL bp_req1_rsp: got v=%b id=%b r=%h want 1/1/0c", rsp_valid, rsp_id, rsp_result); end
        step();
    endtask

    task automatic test_opcodes();
        vec_t v [12];
        v = '{
            '{3'd0, 8'hF0, 8'h20, 8'h10},
            '{3'd0, 8'h80, 8'h80, 8'h00},
            '{3'd1, 8'h80, 8'h01, 8'h7F},
            '{3'd7, 8'h80, 8'h01, 8'h40},
            '{3'd5, 8'h80, 8'h09, 8'h00},
            '{3'd3, 8'h0F, 8'hF0, 8'h00},
            '{3'd2, 8'hF0, 8'h3C, 8'h30},
            '{3'd4, 8'hA5, 8'hFF, 8'h5A},
            '{3'd6, 8'h80, 8'h03, 8'h10},
            '{3'd5, 8'h01, 8'h07, 8'h80},
            '{3'd1, 8'h00, 8'h01, 8'hFF},
            '{3'd6, 8'h80, 8'h08, 8'h00}
        };
        rsp_ready = 1'b1;
        set_req(1, 3'd0, 8'hEE, 8'hEE);
        for (int i = 0; i < 12; i++) begin
            set_req(0, v[i].op, v[i].x, v[i].y);
            req_valid = 2'b01;
            #1;
            n_chk++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL op_ready %0d: got %b want 01", i, req_ready); end
            step();
            req_valid = 2'b00;
            #1;
            n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL op_latency %0d: got %b want 0", i, rsp_valid); end
            step();
            #1;
            n_chk++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== v[i].r) begin n_fail++; $display("FAIL op_result %0d: got v=%b id=%b r=%h want 1/0/%h", i, rsp_valid, rsp_id, rsp_result, v[i].r); end
            step();
        end
    endtask

    task automatic test_reset_in_resp();
        rsp_ready = 1'b0;
        set_req(0, 3'd0, 8'h01, 8'h02);
        set_req(1, 3'd0, 8'h11, 8'h22);
        req_valid = 2'b10;
        #1;
        n_chk++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL rr_grant1: got %b want 10", req_ready); end
        step();
        req_valid = 2'b00;
        step();
        #1;
        n_chk++; if (rsp_valid !== 1'b1 || rsp_result !== 8'h33) begin n_fail++; $display("FAIL rr_in_resp: got v=%b r=%h want 1/33", rsp_valid, rsp_result); end
        i_rst_n = 1'b0;
        #1;
        n_chk++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rr_async_drop: got v=%b busy=%b want 0/0", rsp_valid, busy); end
        n_chk++; if (rsp_result !== 8'h00 || rsp_id !== 1'b0) begin n_fail++; $display("FAIL rr_async_clear: got r=%h id=%b want 00/0", rsp_result, rsp_id); end
        req_valid = 2'b11;
        #1;
        n_chk++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL rr_ready_in_reset: got %b want 00", req_ready); end
        step();
        step();
        i_rst_n   = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_chk++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rr_stale %0d: got v=%b busy=%b want 0/0", i, rsp_valid, busy); end
            step();
        end
        req_valid = 2'b11;
        #1;
        n_chk++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL rr_first_after: got %b want 01", req_ready); end
        step();
        req_valid = 2'b00;
        step();
        #1;
        n_chk++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 8'h03) begin n_fail++; $display("FAIL rr_post_rsp: got v=%b id=%b r=%h want 1/0/03", rsp_valid, rsp_id, rsp_result); end
        step();
    endtask

    initial begin
        i_rst_n   = 1'b0;
        req_valid = 2'b00;
        req_op    = '0;
        req_x     = '0;
        req_y     = '0;
        rsp_ready = 1'b0;
        test_reset();
        test_contention();
        test_backpressure();
        test_opcodes();
        test_reset_in_resp();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_alu_arbiter
`default_nettype wire

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter NREQ, default 2: number of requesters sharing the ALU; legal range 2..4.
REQ-002 Parameter DATA_W, default 8: operand/result width; fixed at 8 to match the ALU.
REQ-003 i_clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 i_req_valid  input  NREQ  per-requester request valid.
REQ-006 o_req_ready  output  NREQ  per-requester accept; at most one bit high per cycle.
REQ-007 i_req_op  input  3*NREQ  per-requester ALU opcode; requester k occupies bits [3k+2:3k].
REQ-008 i_req_x  input  8*NREQ  per-requester operand x; requester k occupies bits [8k+7:8k].
REQ-009 i_req_y  input  8*NREQ  per-requester operand y; packed like i_req_x.
REQ-010 o_rsp_valid  output  1  response valid.
REQ-011 i_rsp_ready  input  1  response consumer ready.
REQ-012 o_rsp_id  output  clog2(NREQ)  index of the requester that owns the response.
REQ-013 o_rsp_result  output  8  ALU result for that request.
REQ-014 o_busy  output  1  high in every state except IDLE.

Function
REQ-015 The block SHALL implement a three-state FSM: IDLE, EXEC, RESP.
REQ-016 In IDLE with any i_req_valid bit high, the block SHALL assert o_req_ready only for the round-robin winner, in the same cycle.
- The winner is the first valid index searched upward from last_grant+1, wrapping modulo NREQ.
REQ-017 A request SHALL be accepted when valid and ready are both high at a clock edge.
- On acceptance the block SHALL capture op, x, y and the winner id into registers.
- On acceptance the block SHALL set last_grant to the winner and move to EXEC.
REQ-018 With no valid request, IDLE SHALL hold, and o_req_ready and last_grant SHALL stay unchanged.
REQ-019 o_req_ready SHALL be all-zero in EXEC and RESP.
REQ-020 In EXEC the block SHALL drive the ALU from the captured registers only.
- It SHALL register the ALU output into o_rsp_result and the captured id into o_rsp_id.
- It SHALL then move to RESP unconditionally.
REQ-021 In RESP, o_rsp_valid SHALL be high, with o_rsp_result and o_rsp_id stable until the handshake completes.
- The handshake completes when i_rsp_ready is high at a clock edge; the block then moves to IDLE.
REQ-022 Latency: a request accepted at edge N SHALL give o_rsp_valid high from edge N+2.
- Minimum issue interval is 3 cycles (no IDLE bypass).
REQ-023 o_rsp_result SHALL equal the ALU output bit-for-bit for the captured operands, with no width extension and no carry output.
- Arithmetic wraps modulo 256.
- Shifts use the full 8-bit y, so any y >= 8 gives 0.
- Opcode 7 on these unsigned operands gives the same result as opcode 6.
REQ-024 Requesters SHALL hold valid and payload stable until accepted.
- The block does not need to tolerate a requester retracting a request.
- o_req_ready may depend combinationally on i_req_valid.
REQ-025 Requests arriving during EXEC or RESP SHALL wait.
- They are arbitrated on the first IDLE cycle using the updated last_grant.
REQ-026 i_rsp_ready high outside RESP SHALL have no effect.

Reset
REQ-027 While i_rst_n is low, the block SHALL force: state IDLE, last_grant NREQ-1 (requester 0 wins first), o_rsp_valid 0, o_rsp_id 0, o_rsp_result 0, o_busy 0.
REQ-028 While i_rst_n is low, o_req_ready SHALL be all-zero.
REQ-029 Reset asserted in EXEC or RESP SHALL drop the transaction: no response is issued after reset deassertion.
REQ-030 Reset deassertion SHALL be treated as synchronous to i_clk.
- The first acceptance may occur in the first cycle after deassertion.

Structure
REQ-031 A shared package alu_pkg SHALL hold:
- DATA_W;
- the 3-bit opcode enum ADD=0, SUB=1, AND=2, NOR=3, XOR=4, SHL=5, SHR=6, SRA=7;
- the FSM state typedef.
REQ-032 The block SHALL instantiate exactly one sub-module, the existing ALU, fed from the capture registers.
- Round-robin selection SHALL be a local function, not a separate module.

Verification
REQ-033 Single request, NREQ=2: req0 op=0 x=0xF0 y=0x20 -> ready0 in the same cycle; o_rsp_valid 2 cycles later with result 0x10, id 0.
REQ-034 Contention: both valid continuously, i_rsp_ready=1 -> grants alternate 0,1,0,1; each response carries the matching id; no grant within 3 cycles of the previous one.
REQ-035 Backpressure: i_rsp_ready=0 for 5 cycles in RESP -> result and id held stable, o_req_ready stays 0, req1 waits; release -> IDLE, then req1 is granted.
REQ-036 Opcode sweep, x=0x80: y=0x80 op=0 gives 0x00; y=1 op=1 gives 0x7F; y=1 op=7 gives 0x40; y=9 op=5 gives 0x00; x=0x0F y=0xF0 op=3 gives 0x00.
REQ-037 Reset in RESP -> o_rsp_valid drops to 0 at once; after release no stale response appears and requester 0 wins first.
